// File: rtl/miriscv_alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_alu_arb_pkg
// Shared definitions for the ALU arbiter slice:
//   - state_e           : response-holding state (EMPTY / FULL)
//   - ARB_NREQ_DEFAULT  : default number of requesters sharing the ALU
//   - ARB_XLEN_DEFAULT  : default datapath width (matches the core XLEN)
//   - ALU_*             : 4-bit ALU opcode encoding seen on alu_op_o
// ---------------------------------------------------------------------------
package miriscv_alu_arb_pkg;

  localparam int ARB_NREQ_DEFAULT = 2;
  localparam int ARB_XLEN_DEFAULT = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Arithmetic / logic ops produce alu_result_i; compare ops produce
  // alu_branch_des_i from the cmp operands.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTS = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LTS  = 4'd12;
  localparam logic [3:0] ALU_GES  = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/miriscv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_rr_arbiter
// Grant selection for the shared ALU.
//   clk, rst : clock and synchronous active-high reset (pointer only)
//   request  : per-requester request vector
//   enable   : grant allowed this cycle
//   grant    : one-hot (or zero) grant, only ever to a requesting index
//   pointer  : index currently holding highest priority
// Build option MIRISCV_ALU_ARB_RR_EN: defined -> round-robin with a pointer
// register; undefined -> fixed priority (index 0 highest), pointer tied 0.
// ---------------------------------------------------------------------------
module miriscv_rr_arbiter
  import miriscv_alu_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEFAULT,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] request,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   pointer
);

  logic [PW-1:0] base;

`ifdef MIRISCV_ALU_ARB_RR_EN
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] ptr_q;

  assign base    = ptr_q;
  assign pointer = ptr_q;

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[PW'(k)]) grant_idx = PW'(k);
    end
  end

  // Priority moves to the requester just after the one served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|grant) begin
      ptr_q <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  logic unused_clk_rst;

  assign base           = '0;
  assign pointer        = '0;
  assign unused_clk_rst = clk ^ rst;
`endif

  // Walk the requesters starting at base, wrapping modulo NREQ; the first
  // active one wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, base} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(NREQ)) sum = sum - (PW + 1)'(NREQ);
      idx = sum[PW-1:0];
      if (enable && !found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miriscv_alu_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_alu_arbiter
// Shares one combinational ALU among NREQ requesters and holds a single
// registered response per owner.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : per-requester request handshake
//   req_op_i, req_a_i, req_b_i, req_cmp_a_i, req_cmp_b_i : request operands
//   alu_op_o, alu_port_a_o, alu_port_b_o, cmp_a_o, cmp_b_o : to the ALU
//   alu_result_i, alu_branch_des_i : ALU outputs, captured on acceptance
//   rsp_valid_o (one-hot owner), rsp_ready_i, rsp_result_o, rsp_branch_o
// Build option MIRISCV_ALU_ARB_RR_EN selects round-robin arbitration
// (see miriscv_rr_arbiter); default build is fixed priority.
// ---------------------------------------------------------------------------
module miriscv_alu_arbiter
  import miriscv_alu_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEFAULT,
  parameter int XLEN = ARB_XLEN_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ-1:0][3:0]      req_op_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_a_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_b_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_cmp_a_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_cmp_b_i,
  output logic [3:0]                alu_op_o,
  output logic [XLEN-1:0]           alu_port_a_o,
  output logic [XLEN-1:0]           alu_port_b_o,
  output logic [XLEN-1:0]           cmp_a_o,
  output logic [XLEN-1:0]           cmp_b_o,
  input  logic [XLEN-1:0]           alu_result_i,
  input  logic                      alu_branch_des_i,
  output logic [NREQ-1:0]           rsp_valid_o,
  input  logic [NREQ-1:0]           rsp_ready_i,
  output logic [XLEN-1:0]           rsp_result_o,
  output logic                      rsp_branch_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state, state_next;
  logic [PW-1:0]   owner;
  logic [XLEN-1:0] result_q;
  logic            branch_q;

  logic            drain;
  logic            arb_enable;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            accept;
  logic [PW-1:0]   unused_pointer;

  // Only the owner's rsp_ready_i frees the holding register; reset blocks
  // all grants so req_ready_o stays low while rst_i is high.
  assign drain      = (state == FULL) && rsp_ready_i[owner];
  assign arb_enable = !rst_i && ((state == EMPTY) || drain);

  miriscv_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .request (req_valid_i),
    .enable  (arb_enable),
    .grant   (grant),
    .pointer (unused_pointer)
  );

  // The arbiter grants only valid requesters, so any grant is a handshake.
  assign accept      = |grant;
  assign req_ready_o = grant;

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[PW'(k)]) gnt_idx = PW'(k);
    end
  end

  // State and response registers; data is only written on acceptance so a
  // held response stays stable under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= EMPTY;
      owner    <= '0;
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner    <= gnt_idx;
        result_q <= alu_result_i;
        branch_q <= alu_branch_des_i;
      end
    end
  end

  // A new acceptance always refills (back-to-back when draining); a drain
  // without a new grant empties the holding register.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = FULL;
    end else if (drain) begin
      state_next = EMPTY;
    end
  end

  // With no grant gnt_idx is 0, so the ALU sees requester 0's inputs.
  always_comb begin
    rsp_valid_o = '0;
    if (state == FULL) rsp_valid_o[owner] = 1'b1;
    alu_op_o     = req_op_i[gnt_idx];
    alu_port_a_o = req_a_i[gnt_idx];
    alu_port_b_o = req_b_i[gnt_idx];
    cmp_a_o      = req_cmp_a_i[gnt_idx];
    cmp_b_o      = req_cmp_b_i[gnt_idx];
    rsp_result_o = result_q;
    rsp_branch_o = branch_q;
  end

`ifndef SYNTHESIS
  // A waiting request must keep valid high with frozen operands.
  for (genvar i = 0; i < NREQ; i++) begin : g_req_stable
    assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        (req_valid_i[i] && $stable(req_op_i[i]) && $stable(req_a_i[i]) &&
         $stable(req_b_i[i]) && $stable(req_cmp_a_i[i]) && $stable(req_cmp_b_i[i])));
  end

  assert property (@(posedge clk_i) $onehot0(req_ready_o));
`endif

endmodule
